// File: rtl/shell_pkg.sv
// Shared constants for the shell sprite renderer: per-slot state type,
// player colours, explosion colour and the two 10x10 sprite masks.
// Mask rows are indexed by grid y; bit n of a row is grid x = n.
package shell_pkg;

   localparam int SPRITE_N    = 10;
   localparam int SPRITE_IDX_W = $clog2(SPRITE_N);
   localparam int MAX_PLAYERS = 4;

   typedef enum logic [1:0] {
      SLOT_IDLE = 2'd0,
      SLOT_FLY  = 2'd1,
      SLOT_BOOM = 2'd2
   } slot_state_t;

   typedef logic [SPRITE_N-1:0] mask_row_t;

   localparam logic [23:0] SHELL_COLOR [MAX_PLAYERS] = '{
      24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFF00
   };
   localparam logic [23:0] SHELL_EXPLODE = 24'hFF8000;

   // Small round shell in the middle of the cell.
   localparam mask_row_t SHELL_MASK [SPRITE_N] = '{
      10'b0000000000,
      10'b0000000000,
      10'b0000000000,
      10'b0000110000,
      10'b0001111000,
      10'b0001111000,
      10'b0000110000,
      10'b0000000000,
      10'b0000000000,
      10'b0000000000
   };

   // X-shaped burst reaching the cell corners.
   localparam mask_row_t EXPLODE_MASK [SPRITE_N] = '{
      10'b1000000001,
      10'b0100000010,
      10'b0010000100,
      10'b0001001000,
      10'b0000110000,
      10'b0000110000,
      10'b0001001000,
      10'b0010000100,
      10'b0100000010,
      10'b1000000001
   };

   // Caller guarantees gy/gx < SPRITE_N.
   function automatic logic mask_bit(input logic                    use_boom,
                                     input logic [SPRITE_IDX_W-1:0] gy,
                                     input logic [SPRITE_IDX_W-1:0] gx);
      mask_row_t row;
      row = use_boom ? EXPLODE_MASK[gy] : SHELL_MASK[gy];
      return row[gx];
   endfunction

endpackage

// File: rtl/shell_sprite_engine_if.sv
// Pixel query / colour result channel of the shell sprite renderer.
//   i_pix_valid, i_display_x/y, i_grid_x/y : query from the video pipeline
//   o_rgb_valid, o_rgb_w                   : registered colour answer
interface shell_sprite_engine_if #(
   parameter int COORD_W = 6,
   parameter int GRID_W  = 4
) ();
   logic               i_pix_valid;
   logic [COORD_W-1:0] i_display_x;
   logic [COORD_W-1:0] i_display_y;
   logic [GRID_W-1:0]  i_grid_x;
   logic [GRID_W-1:0]  i_grid_y;
   logic               o_rgb_valid;
   logic [23:0]        o_rgb_w;

   modport master (
      output i_pix_valid, i_display_x, i_display_y, i_grid_x, i_grid_y,
      input  o_rgb_valid, o_rgb_w
   );

   modport slave (
      input  i_pix_valid, i_display_x, i_display_y, i_grid_x, i_grid_y,
      output o_rgb_valid, o_rgb_w
   );
endinterface

// File: rtl/shell_slot_fsm.sv
// One shell slot: IDLE / FLY / BOOM state, explosion frame counter and the
// cell position the sprite is drawn at. State only moves on i_frame_start.
//   i_active, i_x, i_y : this slot's shell inputs (sampled at frame start)
//   o_state            : current slot state
//   o_x, o_y           : held draw position
//   o_blink            : explosion blanked this frame (counter LSB)
module shell_slot_fsm
   import shell_pkg::*;
#(
   parameter int COORD_W        = 6,
   parameter int EXPLODE_FRAMES = 8
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_frame_start,
   input  logic               i_active,
   input  logic [COORD_W-1:0] i_x,
   input  logic [COORD_W-1:0] i_y,
   output slot_state_t        o_state,
   output logic [COORD_W-1:0] o_x,
   output logic [COORD_W-1:0] o_y,
   output logic               o_blink
);

   slot_state_t        state_q, state_d;
   logic [7:0]         cnt_q, cnt_d;
   logic [COORD_W-1:0] x_q, x_d;
   logic [COORD_W-1:0] y_q, y_d;

   always_comb begin
      // NOTE: every signal gets a hold default first, so no path through the
      // case can leave one unassigned and infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      x_d     = x_q;
      y_d     = y_q;
      if (i_frame_start) begin
         unique case (state_q)
            SLOT_IDLE: begin
               if (i_active) begin
                  state_d = SLOT_FLY;
                  x_d     = i_x;
                  y_d     = i_y;
               end
            end
            SLOT_FLY: begin
               if (i_active) begin
                  x_d = i_x;
                  y_d = i_y;
               end else begin
                  // Explode where the shell was last seen, not at i_x/i_y.
                  state_d = SLOT_BOOM;
                  cnt_d   = 8'(EXPLODE_FRAMES - 1);
               end
            end
            SLOT_BOOM: begin
               if (i_active) begin
                  state_d = SLOT_FLY;
                  cnt_d   = '0;
                  x_d     = i_x;
                  y_d     = i_y;
               end else if (cnt_q == 8'd0) begin
                  state_d = SLOT_IDLE;
               end else begin
                  cnt_d = cnt_q - 8'd1;
               end
            end
            default: state_d = SLOT_IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= SLOT_IDLE;
         cnt_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         x_q     <= x_d;
         y_q     <= y_d;
      end
   end

   assign o_state = state_q;
   assign o_x     = x_q;
   assign o_y     = y_q;
   assign o_blink = cnt_q[0];

endmodule

// File: rtl/shell_sprite_engine.sv
// Shell sprite renderer: keeps one slot FSM per player shell, snapshots the
// shell positions at each frame start and answers per-pixel colour queries.
//   i_clk, i_rst_n        : clock, async active-low reset
//   i_frame_start         : frame pulse, the only time shell inputs are taken
//   i_shell_x/y/active    : packed shell inputs, slot index p*NUM_SHELLS+s
//   pix                   : query/result channel (one-cycle registered answer)
// GRID_W must be at least SPRITE_IDX_W; NUM_PLAYERS at most MAX_PLAYERS.
module shell_sprite_engine
   import shell_pkg::*;
#(
   parameter int NUM_PLAYERS    = 2,
   parameter int NUM_SHELLS     = 5,
   parameter int COORD_W        = 6,
   parameter int GRID_W         = 4,
   parameter int EXPLODE_FRAMES = 8
) (
   input  logic                                     i_clk,
   input  logic                                     i_rst_n,
   input  logic                                     i_frame_start,
   input  logic [NUM_PLAYERS*NUM_SHELLS*COORD_W-1:0] i_shell_x,
   input  logic [NUM_PLAYERS*NUM_SHELLS*COORD_W-1:0] i_shell_y,
   input  logic [NUM_PLAYERS*NUM_SHELLS-1:0]         i_shell_active,
   shell_sprite_engine_if.slave                      pix
);

   localparam int NUM_SLOTS = NUM_PLAYERS * NUM_SHELLS;

   slot_state_t        slot_state [NUM_SLOTS];
   logic [COORD_W-1:0] slot_x     [NUM_SLOTS];
   logic [COORD_W-1:0] slot_y     [NUM_SLOTS];
   logic               slot_blink [NUM_SLOTS];
   logic [NUM_SLOTS-1:0] fly_hit;
   logic [NUM_SLOTS-1:0] boom_hit;

   logic                    in_range;
   logic [SPRITE_IDX_W-1:0] gx_idx;
   logic [SPRITE_IDX_W-1:0] gy_idx;
   logic [23:0]             pix_color;

   logic        rgb_valid_q, rgb_valid_d;
   logic [23:0] rgb_q, rgb_d;

   assign in_range = (pix.i_grid_x < GRID_W'(SPRITE_N)) &&
                     (pix.i_grid_y < GRID_W'(SPRITE_N));
   assign gx_idx   = pix.i_grid_x[SPRITE_IDX_W-1:0];
   assign gy_idx   = pix.i_grid_y[SPRITE_IDX_W-1:0];

   for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
      logic pos_match;

      shell_slot_fsm #(
         .COORD_W        (COORD_W),
         .EXPLODE_FRAMES (EXPLODE_FRAMES)
      ) u_slot (
         .i_clk         (i_clk),
         .i_rst_n       (i_rst_n),
         .i_frame_start (i_frame_start),
         .i_active      (i_shell_active[i]),
         .i_x           (i_shell_x[i*COORD_W +: COORD_W]),
         .i_y           (i_shell_y[i*COORD_W +: COORD_W]),
         .o_state       (slot_state[i]),
         .o_x           (slot_x[i]),
         .o_y           (slot_y[i]),
         .o_blink       (slot_blink[i])
      );

      assign pos_match   = (slot_x[i] == pix.i_display_x) &&
                           (slot_y[i] == pix.i_display_y);
      assign fly_hit[i]  = in_range && pos_match && (slot_state[i] == SLOT_FLY) &&
                           mask_bit(1'b0, gy_idx, gx_idx);
      assign boom_hit[i] = in_range && pos_match && (slot_state[i] == SLOT_BOOM) &&
                           !slot_blink[i] && mask_bit(1'b1, gy_idx, gx_idx);
   end

   // Ascending scan: a later (higher-index) player with any hit overrides.
   always_comb begin
      pix_color = 24'h0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
         if (|fly_hit[p*NUM_SHELLS +: NUM_SHELLS]) begin
            pix_color = SHELL_COLOR[p];
         end else if (|boom_hit[p*NUM_SHELLS +: NUM_SHELLS]) begin
            pix_color = SHELL_EXPLODE;
         end
      end
   end

   // Colour comes from the current (pre-frame-update) slot state.
   always_comb begin
      rgb_valid_d = pix.i_pix_valid;
      rgb_d       = pix.i_pix_valid ? pix_color : rgb_q;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rgb_valid_q <= 1'b0;
         rgb_q       <= 24'h0;
      end else begin
         rgb_valid_q <= rgb_valid_d;
         rgb_q       <= rgb_d;
      end
   end

   assign pix.o_rgb_valid = rgb_valid_q;
   assign pix.o_rgb_w     = rgb_q;

endmodule

// File: tb/tb_shell_sprite_engine.sv
// Self-checking bench for shell_sprite_engine: a per-slot behavioural model
// predicts every output cycle, directed scenarios add literal expectations.
module tb_shell_sprite_engine;
   import shell_pkg::*;

   localparam int NP = 2;
   localparam int NS = 5;
   localparam int NT = NP * NS;
   localparam int CW = 6;
   localparam int GW = 4;
   localparam int EF = 8;

   localparam logic [23:0] RED    = 24'hFF0000;
   localparam logic [23:0] GREEN  = 24'h00FF00;
   localparam logic [23:0] ORANGE = 24'hFF8000;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   logic frame_start = 1'b0;
   logic [NT*CW-1:0] shell_x      = '0;
   logic [NT*CW-1:0] shell_y      = '0;
   logic [NT-1:0]    shell_active = '0;

   shell_sprite_engine_if #(.COORD_W(CW), .GRID_W(GW)) pix ();

   shell_sprite_engine #(
      .NUM_PLAYERS    (NP),
      .NUM_SHELLS     (NS),
      .COORD_W        (CW),
      .GRID_W         (GW),
      .EXPLODE_FRAMES (EF)
   ) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_frame_start  (frame_start),
      .i_shell_x      (shell_x),
      .i_shell_y      (shell_y),
      .i_shell_active (shell_active),
      .pix            (pix)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef enum {M_IDLE, M_FLY, M_BOOM} m_kind_t;
   m_kind_t     m_kind [NT] = '{default: M_IDLE};
   int          m_cnt  [NT] = '{default: 0};
   int          m_x    [NT] = '{default: 0};
   int          m_y    [NT] = '{default: 0};
   logic        exp_valid = 1'b0;
   logic [23:0] exp_rgb   = 24'h0;

   function automatic logic [23:0] model_pixel(input int dx, input int dy,
                                               input int gx, input int gy);
      if (gx >= 10 || gy >= 10) return 24'h0;
      for (int p = NP - 1; p >= 0; p--) begin
         bit f = 1'b0;
         bit b = 1'b0;
         for (int s = 0; s < NS; s++) begin
            int i = p * NS + s;
            if (m_x[i] == dx && m_y[i] == dy) begin
               if (m_kind[i] == M_FLY && SHELL_MASK[gy][gx]) f = 1'b1;
               if (m_kind[i] == M_BOOM && (m_cnt[i] % 2) == 0 && EXPLODE_MASK[gy][gx]) b = 1'b1;
            end
         end
         if (f) return SHELL_COLOR[p];
         if (b) return SHELL_EXPLODE;
      end
      return 24'h0;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NT; i++) begin
            m_kind[i] <= M_IDLE;
            m_cnt[i]  <= 0;
            m_x[i]    <= 0;
            m_y[i]    <= 0;
         end
         exp_valid <= 1'b0;
         exp_rgb   <= 24'h0;
      end else begin
         exp_valid <= pix.i_pix_valid;
         if (pix.i_pix_valid)
            exp_rgb <= model_pixel(int'(pix.i_display_x), int'(pix.i_display_y),
                                   int'(pix.i_grid_x), int'(pix.i_grid_y));
         if (frame_start) begin
            for (int i = 0; i < NT; i++) begin
               if (shell_active[i]) begin
                  m_kind[i] <= M_FLY;
                  m_cnt[i]  <= 0;
                  m_x[i]    <= int'(shell_x[i*CW +: CW]);
                  m_y[i]    <= int'(shell_y[i*CW +: CW]);
               end else if (m_kind[i] == M_FLY) begin
                  m_kind[i] <= M_BOOM;
                  m_cnt[i]  <= EF - 1;
               end else if (m_kind[i] == M_BOOM) begin
                  if (m_cnt[i] == 0) m_kind[i] <= M_IDLE;
                  else               m_cnt[i]  <= m_cnt[i] - 1;
               end
            end
         end
      end
   end

   // Every out-of-reset cycle: DUT outputs against the model.
   always @(negedge clk) begin
      if (rst_n) begin
         check("model_valid", 24'(pix.o_rgb_valid), 24'(exp_valid));
         check("model_rgb", pix.o_rgb_w, exp_rgb);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic frame();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   task automatic drive_query(input int dx, input int dy, input int gx, input int gy);
      pix.i_pix_valid = 1'b1;
      pix.i_display_x = CW'(dx);
      pix.i_display_y = CW'(dy);
      pix.i_grid_x    = GW'(gx);
      pix.i_grid_y    = GW'(gy);
   endtask

   task automatic query(input int dx, input int dy, input int gx, input int gy);
      drive_query(dx, dy, gx, gy);
      tick();
      pix.i_pix_valid = 1'b0;
   endtask

   task automatic set_shell(input int idx, input bit act, input int x, input int y);
      shell_active[idx]       = act;
      shell_x[idx*CW +: CW]   = CW'(x);
      shell_y[idx*CW +: CW]   = CW'(y);
   endtask

   initial begin
      pix.i_pix_valid = 1'b0;
      pix.i_display_x = '0;
      pix.i_display_y = '0;
      pix.i_grid_x    = '0;
      pix.i_grid_y    = '0;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_valid", 24'(pix.o_rgb_valid), 24'h0);
      check("reset_rgb", pix.o_rgb_w, 24'h0);
      rst_n = 1'b1;
      tick();

      // Flight: p0 s2 at (5,7); ignored until the first frame pulse.
      set_shell(2, 1'b1, 5, 7);
      query(5, 7, 4, 4);
      check("pre_frame_ignored", pix.o_rgb_w, 24'h0);
      frame();
      query(5, 7, 4, 4);
      check("fly_hit", pix.o_rgb_w, RED);
      check("fly_valid", 24'(pix.o_rgb_valid), 24'h1);
      query(5, 8, 4, 4);
      check("fly_wrong_cell", pix.o_rgb_w, 24'h0);
      query(5, 7, 0, 0);
      check("fly_mask_zero", pix.o_rgb_w, 24'h0);
      query(5, 7, 4, 4);
      query(5, 7, 12, 4);
      check("grid_x_out_of_range", pix.o_rgb_w, 24'h0);
      query(5, 7, 4, 10);
      check("grid_y_out_of_range", pix.o_rgb_w, 24'h0);

      // Explosion: deactivate with new coords; burst stays at (5,7).
      set_shell(2, 1'b0, 9, 9);
      frame();
      query(5, 7, 0, 0);
      check("boom_blank_odd", pix.o_rgb_w, 24'h0);
      frame();
      query(5, 7, 0, 0);
      check("boom_visible_even", pix.o_rgb_w, ORANGE);
      query(9, 9, 0, 0);
      check("boom_not_at_new_xy", pix.o_rgb_w, 24'h0);
      for (int k = 3; k <= EF; k++) begin
         frame();
         query(5, 7, 0, 0);
      end
      // Pulse and query together: pixel uses the last BOOM frame.
      frame_start = 1'b1;
      drive_query(5, 7, 0, 0);
      tick();
      frame_start = 1'b0;
      pix.i_pix_valid = 1'b0;
      check("coincident_pre_update", pix.o_rgb_w, ORANGE);
      query(5, 7, 0, 0);
      check("boom_idle_after_frames", pix.o_rgb_w, 24'h0);

      // Priority between players at (3,3).
      set_shell(0, 1'b1, 3, 3);
      set_shell(6, 1'b1, 3, 3);
      frame();
      query(3, 3, 4, 4);
      check("prio_fly_fly", pix.o_rgb_w, GREEN);
      set_shell(6, 1'b0, 3, 3);
      frame();
      query(3, 3, 4, 4);
      check("prio_p1_blank", pix.o_rgb_w, RED);
      frame();
      query(3, 3, 4, 4);
      check("prio_boom_over_fly", pix.o_rgb_w, ORANGE);

      // Freeze: moving p0 s0 without a pulse changes nothing.
      query(3, 3, 3, 4);
      check("freeze_before", pix.o_rgb_w, RED);
      set_shell(0, 1'b1, 10, 3);
      tick();
      tick();
      query(3, 3, 3, 4);
      check("freeze_held", pix.o_rgb_w, RED);
      frame();
      query(3, 3, 3, 4);
      check("freeze_moved_away", pix.o_rgb_w, 24'h0);
      query(10, 3, 3, 4);
      check("freeze_new_pos", pix.o_rgb_w, RED);

      // Re-fire: exploding p1 s1 becomes active at (1,1).
      frame();
      query(3, 3, 4, 4);
      check("refire_boom_before", pix.o_rgb_w, ORANGE);
      set_shell(6, 1'b1, 1, 1);
      frame();
      query(3, 3, 4, 4);
      check("refire_boom_gone", pix.o_rgb_w, 24'h0);
      query(1, 1, 4, 4);
      check("refire_fly", pix.o_rgb_w, GREEN);

      // Reset in the middle of an explosion.
      set_shell(0, 1'b0, 0, 0);
      set_shell(6, 1'b0, 0, 0);
      set_shell(2, 1'b1, 5, 7);
      frame();
      set_shell(2, 1'b0, 5, 7);
      frame();
      frame();
      query(5, 7, 0, 0);
      check("rst_boom_before", pix.o_rgb_w, ORANGE);
      drive_query(5, 7, 0, 0);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_async_valid", 24'(pix.o_rgb_valid), 24'h0);
      check("rst_async_rgb", pix.o_rgb_w, 24'h0);
      pix.i_pix_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      set_shell(2, 1'b1, 5, 7);
      query(5, 7, 4, 4);
      check("rst_ignore_until_frame", pix.o_rgb_w, 24'h0);
      query(5, 7, 0, 0);
      check("rst_no_boom", pix.o_rgb_w, 24'h0);
      set_shell(2, 1'b0, 5, 7);
      frame();
      query(5, 7, 0, 0);
      check("rst_no_boom_resume", pix.o_rgb_w, 24'h0);
      tick();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/shell_sprite_engine.md
SHELL_SPRITE_ENGINE -- requirements
Module: shell_sprite_engine

Interface
REQ-001 SHALL have parameter NUM_PLAYERS, default 2, number of shell-owning players.
REQ-002 SHALL have parameter NUM_SHELLS, default 5, shell slots per player.
REQ-003 SHALL have parameter COORD_W, default 6, width of display-cell coordinates.
REQ-004 SHALL have parameter GRID_W, default 4, width of intra-cell pixel coordinates (sprite 10x10).
REQ-005 SHALL have parameter EXPLODE_FRAMES, default 8, frames an explosion persists (range 1..255).
REQ-006 SHALL have port i_clk  input  1  single clock; all state on rising edge.
REQ-007 SHALL have port i_rst_n  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port i_frame_start  input  1  one-cycle pulse at start of each video frame.
REQ-009 SHALL have port i_shell_x  input  NUM_PLAYERS*NUM_SHELLS*COORD_W  packed shell cell x, slot s of player p at index p*NUM_SHELLS+s.
REQ-010 SHALL have port i_shell_y  input  NUM_PLAYERS*NUM_SHELLS*COORD_W  packed shell cell y, same indexing.
REQ-011 SHALL have port i_shell_active  input  NUM_PLAYERS*NUM_SHELLS  1 = shell in flight (active-high).
REQ-012 SHALL have port i_pix_valid  input  1  pixel query valid this cycle.
REQ-013 SHALL have ports i_display_x, i_display_y  input  COORD_W each  queried cell.
REQ-014 SHALL have ports i_grid_x, i_grid_y  input  GRID_W each  pixel within cell.
REQ-015 SHALL have port o_rgb_valid  output  1  o_rgb_w holds a result.
REQ-016 SHALL have port o_rgb_w  output  24  pixel colour, 24'h0 = transparent.

Function
REQ-017 SHALL sample i_shell_x/y/active only on cycles with i_frame_start=1; between pulses the snapshot is frozen, so a frame renders from one consistent set.
REQ-018 SHALL keep per-slot state IDLE / FLY / BOOM plus 8-bit boom counter and held position.
REQ-019 SHALL, at i_frame_start: IDLE+active -> FLY; FLY+active -> FLY (position updated); FLY+!active -> BOOM, counter=EXPLODE_FRAMES-1, position held at last FLY position.
REQ-020 SHALL, at i_frame_start in BOOM: active -> FLY with new position, counter cleared; else counter==0 -> IDLE; else counter decrements.
REQ-021 SHALL leave all slot state unchanged on cycles without i_frame_start.
REQ-022 SHALL treat a slot as hit when its state is FLY or BOOM, its position equals (i_display_x, i_display_y), and its sprite mask bit at (i_grid_y, i_grid_x) is 1; FLY uses shell mask, BOOM uses explosion mask.
REQ-023 SHALL blank BOOM slots whose counter bit 0 is 1 (explosion blinks at half frame rate).
REQ-024 SHALL resolve colour: highest-index player with any hit wins; within that player, any FLY hit gives SHELL_COLOR[p], else SHELL_EXPLODE; no hit gives 24'h0.
REQ-025 SHALL return 24'h0 for i_grid_x or i_grid_y >= 10.
REQ-026 SHALL register output: o_rgb_valid = i_pix_valid delayed 1 cycle; o_rgb_w updates only when i_pix_valid=1, else holds.
REQ-027 SHALL, when i_frame_start and i_pix_valid coincide, render that pixel from pre-update state.

Reset
REQ-028 SHALL on i_rst_n=0 immediately force all slots IDLE, counters and held positions 0, o_rgb_valid 0, o_rgb_w 24'h0.
REQ-029 SHALL, after reset release, ignore shells until the first i_frame_start.
REQ-030 SHALL, if reset asserts mid-explosion, discard it; no BOOM resumes afterwards.

Structure
REQ-031 SHALL take SHELL_COLOR array, SHELL_EXPLODE, SPRITE_N=10 and both 10x10 masks as constants from shared package shell_pkg.
REQ-032 SHALL implement per-slot FSM/counter/position as sub-module shell_slot_fsm, instantiated NUM_PLAYERS*NUM_SHELLS times via generate.

Verification
REQ-033 SHALL verify reset: assert i_rst_n=0 mid-BOOM -> o_rgb_w=0, o_rgb_valid=0 same cycle; after release, pixel queries return 0 until the first i_frame_start.
REQ-034 SHALL verify flight: p0 s2 active at (5,7), pulse frame -> query (5,7) with shell-mask-1 pixel gives SHELL_COLOR[0] one cycle later; (5,8) gives 0.
REQ-035 SHALL verify explosion: deactivate p0 s2 with x/y changed to (9,9) -> explosion at (5,7) visible on frames with counter even, absent at (9,9), IDLE after 8 frames.
REQ-036 SHALL verify priority: p0 and p1 both FLY at (3,3) -> SHELL_COLOR[1]; p1 BOOM + p0 FLY at same cell -> SHELL_EXPLODE.
REQ-037 SHALL verify freeze: change i_shell_x mid-frame without pulse -> output unchanged until next i_frame_start.
REQ-038 SHALL verify re-fire: BOOM slot becomes active at (1,1) -> next frame FLY at (1,1), explosion gone.
